// File: rtl/sincos.sv
`default_nettype none
// ============================================================================
// sincos : pipelined CORDIC rotation-mode cosine/sine generator
// Rev 1.0
// ============================================================================
module sincos #(
  parameter int WIDTH = 16,
  parameter int ITER  = WIDTH - 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sink_valid,
  input  logic signed [WIDTH-1:0] sink,
  output logic                    source_valid,
  output logic signed [WIDTH-1:0] source_x,
  output logic signed [WIDTH-1:0] source_y
);

  localparam int XW = WIDTH + 2;
  localparam int ZW = WIDTH + 1;

  // atan(2^-k) in radians; beyond k=11 atan(2^-k) equals 2^-k well below one LSB
  function automatic real atan_pow2(input int k);
    case (k)
      0:       return 0.7853981633974483;
      1:       return 0.4636476090008061;
      2:       return 0.24497866312686414;
      3:       return 0.12435499454676144;
      4:       return 0.06241880999595735;
      5:       return 0.031239833430268277;
      6:       return 0.015623728620476831;
      7:       return 0.007812341060101111;
      8:       return 0.0039062301319669718;
      9:       return 0.0019531225164788188;
      10:      return 0.0009765621895593195;
      11:      return 0.0004882812111948983;
      default: return 2.0 ** (-k);
    endcase
  endfunction

  function automatic int scale_round(input real v, input int sh);
    return $rtoi(v * (2.0 ** sh) + 0.5);
  endfunction

  localparam logic signed [ZW-1:0] PI     = ZW'(scale_round(3.141592653589793, WIDTH - 3));
  localparam logic signed [ZW-1:0] HALF   = ZW'(scale_round(1.5707963267948966, WIDTH - 3));
  localparam logic signed [XW-1:0] K0     = XW'(scale_round(0.6072529350, WIDTH - 2));
  localparam logic signed [XW-1:0] SAT_HI = XW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_LO = -SAT_HI;

  logic signed [ZW-1:0] ang_tab [0:ITER-1];

  for (genvar k = 0; k < ITER; k++) begin : g_ang
    localparam logic signed [ZW-1:0] ANG = ZW'(scale_round(atan_pow2(k), WIDTH - 3));
    assign ang_tab[k] = ANG;
  end

  logic [ITER:0]        vld;
  logic signed [XW-1:0] x_p [0:ITER];
  logic signed [XW-1:0] y_p [0:ITER];
  logic signed [ZW-1:0] z_p [0:ITER];
  logic signed [ZW-1:0] sink_ext;

  assign sink_ext = {sink[WIDTH-1], sink};

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[WIDTH-1:0];
    else if (v < SAT_LO) return SAT_LO[WIDTH-1:0];
    else                 return v[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i <= ITER; i++) begin
        x_p[i] <= '0;
        y_p[i] <= '0;
        z_p[i] <= '0;
      end
      source_valid <= 1'b0;
      source_x     <= '0;
      source_y     <= '0;
    end else begin
      // Fold the phase into [-pi/2, pi/2]; a half-turn is absorbed by negating x0
      vld[0] <= sink_valid;
      y_p[0] <= '0;
      if (sink_ext > HALF) begin
        z_p[0] <= sink_ext - PI;
        x_p[0] <= -K0;
      end else if (sink_ext < -HALF) begin
        z_p[0] <= sink_ext + PI;
        x_p[0] <= -K0;
      end else begin
        z_p[0] <= sink_ext;
        x_p[0] <= K0;
      end

      for (int i = 1; i <= ITER; i++) begin
        vld[i] <= vld[i-1];
        if (!z_p[i-1][ZW-1]) begin
          x_p[i] <= x_p[i-1] - (y_p[i-1] >>> (i - 1));
          y_p[i] <= y_p[i-1] + (x_p[i-1] >>> (i - 1));
          z_p[i] <= z_p[i-1] - ang_tab[i-1];
        end else begin
          x_p[i] <= x_p[i-1] + (y_p[i-1] >>> (i - 1));
          y_p[i] <= y_p[i-1] - (x_p[i-1] >>> (i - 1));
          z_p[i] <= z_p[i-1] + ang_tab[i-1];
        end
      end

      source_valid <= vld[ITER];
      if (vld[ITER]) begin
        source_x <= sat(x_p[ITER]);
        source_y <= sat(y_p[ITER]);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sincos.sv
`default_nettype none
// ============================================================================
// tb_sincos : directed self-checking bench for the sincos CORDIC generator
// Rev 1.0
// ============================================================================
module tb_sincos;

  localparam int WIDTH = 16;
  localparam int LAT   = 16;
  localparam int TOL   = 4;
  localparam int NV    = 13;
  localparam int NS    = 32;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    sink_valid = 1'b0;
  logic signed [WIDTH-1:0] sink = '0;
  logic                    source_valid;
  logic signed [WIDTH-1:0] source_x;
  logic signed [WIDTH-1:0] source_y;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sincos #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .sink_valid   (sink_valid),
    .sink         (sink),
    .source_valid (source_valid),
    .source_x     (source_x),
    .source_y     (source_y)
  );

  // phase, 16384*cos(phase/8192), 16384*sin(phase/8192)
  int vec_ph [NV] = '{0, 12868, -25736, 8579, 32767, -32768, -12868, 4289, 25736, 6434, -20000, 12869, -12869};
  int vec_ex [NV] = '{16384, 0, -16384, 8192, -10711, -10709, 0, 14189, -16384, 11585, -12529, -2, -2};
  int vec_ey [NV] = '{0, 16384, 0, 14189, -12398, 12400, -16384, 8192, 0, 11585, -10557, 16384, -16384};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp);
    int diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    checks++;
    assert ((diff <= TOL) === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, TOL);
    end
  endtask

  task automatic single(input int idx);
    int early;
    early = 0;
    sink       = WIDTH'(vec_ph[idx]);
    sink_valid = 1'b1;
    step();
    sink_valid = 1'b0;
    if (source_valid) early++;
    for (int i = 2; i < LAT; i++) begin
      step();
      if (source_valid) early++;
    end
    step();
    check_eq($sformatf("early_valid_ph%0d", vec_ph[idx]), early, 0);
    check_eq($sformatf("valid_at_lat_ph%0d", vec_ph[idx]), int'(source_valid), 1);
    check_near($sformatf("x_ph%0d", vec_ph[idx]), int'(source_x), vec_ex[idx]);
    check_near($sformatf("y_ph%0d", vec_ph[idx]), int'(source_y), vec_ey[idx]);
    step();
    check_eq($sformatf("pulse_end_ph%0d", vec_ph[idx]), int'(source_valid), 0);
    check_near($sformatf("x_hold_ph%0d", vec_ph[idx]), int'(source_x), vec_ex[idx]);
    check_near($sformatf("y_hold_ph%0d", vec_ph[idx]), int'(source_y), vec_ey[idx]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS-1:0] pat;
    int q[$];
    int nxt, k, obs_idx, early, last_x, last_y;
    bit have_last, exp_v;

    // Reset state
    repeat (3) step();
    check_eq("reset_valid", int'(source_valid), 0);
    check_eq("reset_x", int'(source_x), 0);
    check_eq("reset_y", int'(source_y), 0);
    reset = 1'b0;
    step();

    // Isolated samples, including fold boundaries and range extremes
    for (int i = 0; i < NV; i++) single(i);

    // Gapped stream: valid pattern must reappear LAT cycles later, values in order
    pat = 32'b1011_0010_1110_0101_1001_1100_0110_1011;
    nxt = 0;
    have_last = 1'b0;
    last_x = 0;
    last_y = 0;
    for (int t = 0; t < NS + LAT; t++) begin
      if (t < NS) begin
        sink_valid = pat[t];
        sink       = WIDTH'(vec_ph[nxt % NV]);
        if (pat[t]) begin
          q.push_back(nxt % NV);
          nxt++;
        end
      end else begin
        sink_valid = 1'b0;
      end
      step();
      obs_idx = t - (LAT - 1);
      exp_v = (obs_idx >= 0 && obs_idx < NS) ? pat[obs_idx] : 1'b0;
      check_eq($sformatf("stream_valid_t%0d", t), int'(source_valid), int'(exp_v));
      if (exp_v && q.size() > 0) begin
        k = q.pop_front();
        last_x = vec_ex[k];
        last_y = vec_ey[k];
        have_last = 1'b1;
        check_near($sformatf("stream_x_t%0d", t), int'(source_x), last_x);
        check_near($sformatf("stream_y_t%0d", t), int'(source_y), last_y);
      end else if (have_last) begin
        check_near($sformatf("stream_hold_x_t%0d", t), int'(source_x), last_x);
        check_near($sformatf("stream_hold_y_t%0d", t), int'(source_y), last_y);
      end
    end

    // Reset with 8 samples in flight; sample presented during reset is ignored
    sink       = WIDTH'(12868);
    sink_valid = 1'b1;
    repeat (8) step();
    reset = 1'b1;
    step();
    reset      = 1'b0;
    sink_valid = 1'b0;
    check_eq("midreset_valid", int'(source_valid), 0);
    check_eq("midreset_x", int'(source_x), 0);
    check_eq("midreset_y", int'(source_y), 0);
    early = 0;
    repeat (24) begin
      step();
      if (source_valid) early++;
    end
    check_eq("flushed_valids", early, 0);
    single(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
